// File: rtl/rr_mux_arbiter_4_pkg.sv
// Shared types for the four-way round-robin arbiter slice.
// Consumed by rr_pick_4, rr_mux_arbiter_4 and rr_mux_arbiter_4_if.
package rr_mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;

  function automatic logic [N_REQ-1:0] idx_onehot(input req_idx_t idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_4_if.sv
// Requester and consumer bundle of the round-robin arbiter.
// in_last exists only when RR_MUX_ARB_BURST_EN is defined.
interface rr_mux_arbiter_4_if #(
  parameter int WIDTH = 4
);
  import rr_mux_arb_pkg::*;

  logic [N_REQ-1:0]       in_valid;
  logic [N_REQ*WIDTH-1:0] in_data;
`ifdef RR_MUX_ARB_BURST_EN
  logic [N_REQ-1:0]       in_last;
`endif
  logic [N_REQ-1:0]       in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  req_idx_t               out_src;
  logic                   out_ready;

  // slave is the arbiter's view; master is the requester/consumer side.
`ifdef RR_MUX_ARB_BURST_EN
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );
`endif

endinterface

// File: rtl/rr_mux_arbiter_4_pick.sv
// rr_pick_4: combinational rotate-priority picker; ptr names the
// highest-priority requester, then ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick_4
  import rr_mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         ptr,
  output req_idx_t         sel,
  output logic [N_REQ-1:0] gnt,
  output logic             any
);

  logic [N_REQ-1:0] rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot_req[gi] = req[req_idx_t'(ptr + req_idx_t'(gi))];
    end
  endgenerate

  // Scan from the far end so the offset nearest ptr wins.
  always_comb begin
    sel = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        sel = req_idx_t'(ptr + req_idx_t'(k));
      end
    end
  end

  assign any = |req;
  assign gnt = any ? idx_onehot(sel) : '0;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four-way round-robin valid/ready arbiter with a one-entry output register.
// Optional burst locking on in_last is enabled by RR_MUX_ARB_BURST_EN.
module rr_mux_arbiter_4
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_4_if.slave bus
);

  arb_state_t       state_reg, state_next;
  req_idx_t         ptr_reg, ptr_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  req_idx_t         out_src_reg, out_src_next;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [WIDTH-1:0] sel_data;
  logic [N_REQ-1:0] pick_req;
  req_idx_t         pick_ptr;
  req_idx_t         sel;
  logic [N_REQ-1:0] gnt;
  logic             any;
  logic             out_valid;
  logic             can_load;
  logic             accept;

`ifdef RR_MUX_ARB_BURST_EN
  logic             lock_reg, lock_next;
  req_idx_t         lock_src_reg, lock_src_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef RR_MUX_ARB_BURST_EN
  // A locked burst only ever looks at its owner.
  assign pick_req = lock_reg ? (bus.in_valid & idx_onehot(lock_src_reg)) : bus.in_valid;
  assign pick_ptr = lock_reg ? lock_src_reg : ptr_reg;
`else
  assign pick_req = bus.in_valid;
  assign pick_ptr = ptr_reg;
`endif

  rr_pick_4 u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .sel (sel),
    .gnt (gnt),
    .any (any)
  );

  assign sel_data  = data_arr[sel];
  assign out_valid = (state_reg == ARB_FULL);
  // rst_n gates loading so in_ready drops the instant reset is applied.
  assign can_load  = rst_n && (!out_valid || bus.out_ready);
  assign accept    = any && can_load;

  assign bus.in_ready  = gnt & {N_REQ{can_load}};
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_reg;
  assign bus.out_src   = out_src_reg;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    out_data_next = out_data_reg;
    out_src_next  = out_src_reg;
`ifdef RR_MUX_ARB_BURST_EN
    lock_next     = lock_reg;
    lock_src_next = lock_src_reg;
`endif

    case (state_reg)
      ARB_EMPTY: if (accept) state_next = ARB_FULL;
      ARB_FULL:  if (bus.out_ready && !accept) state_next = ARB_EMPTY;
      default:   state_next = ARB_EMPTY;
    endcase

    if (accept) begin
      out_data_next = sel_data;
      out_src_next  = sel;
`ifdef RR_MUX_ARB_BURST_EN
      if (bus.in_last[sel]) begin
        lock_next = 1'b0;
        ptr_next  = req_idx_t'(sel + 2'd1);
      end else begin
        lock_next     = 1'b1;
        lock_src_next = sel;
      end
`else
      ptr_next = req_idx_t'(sel + 2'd1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ARB_EMPTY;
      ptr_reg      <= '0;
      out_data_reg <= '0;
      out_src_reg  <= '0;
`ifdef RR_MUX_ARB_BURST_EN
      lock_reg     <= 1'b0;
      lock_src_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      out_data_reg <= out_data_next;
      out_src_reg  <= out_src_next;
`ifdef RR_MUX_ARB_BURST_EN
      lock_reg     <= lock_next;
      lock_src_reg <= lock_src_next;
`endif
    end
  end

endmodule

// File: doc/rr_mux_arbiter_4.md
# rr_mux_arbiter_4

Round-robin arbiter that shares one `WIDTH`-bit output channel between four valid/ready requesters. It drives the select of a 4:1 data mux and registers the chosen beat into a one-entry output stage. It sits in front of any single-consumer datapath fed by multiple sources, such as a shared display or UART byte lane. Throughput is one beat per cycle, and the arbitration is starvation-free.

## Interface
- `WIDTH`, default 4, data width of every requester and of the output.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  4  per-requester valid; bit i belongs to requester i.
- `in_data`  in  4×`WIDTH`  packed requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- `in_last`  in  4  per-requester last-beat flag; present only with `RR_MUX_ARB_BURST_EN`.
- `in_ready`  out  4  per-requester accept strobe.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  `WIDTH`  registered beat.
- `out_src`  out  2  index of the requester that supplied `out_data`.
- `out_ready`  in  1  consumer accepts the beat.
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
- The round-robin pointer `ptr` (2 bits) names the highest-priority requester. Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- `sel` is the first requester with `in_valid` set, searching from `ptr`. `gnt` is the one-hot form of `sel`. Both are combinational.
- `can_load` = !`out_valid` || `out_ready`.
- `in_ready[i]` = `gnt[i]` && `can_load`. At most one bit is ever set, and `in_ready` never depends on `in_ready`.
- A beat is accepted when `in_valid[sel]` && `can_load`. On acceptance:
  - `out_data` ← `in_data[sel]`
  - `out_src` ← `sel`
  - `out_valid` ← 1
  - `ptr` ← `sel`+1 mod 4
- If `out_valid` && `out_ready` and nothing is accepted, then `out_valid` ← 0.
- With `out_valid` && !`out_ready`, the output register is stalled:
  - `out_data` and `out_src` hold.
  - All `in_ready` are 0.
  - `ptr` holds.
- FSM in `arb_state_t`:
  - `ARB_EMPTY` (`out_valid`=0). Go to `ARB_FULL` on acceptance.
  - `ARB_FULL` (`out_valid`=1). Stay on a stall, or on drain plus a same-cycle acceptance. Go to `ARB_EMPTY` on drain with no acceptance.
- Requester contract: once `in_valid[i]` rises, the requester holds it and `in_data` stable until `in_ready[i]`. This is not checked in RTL. The bench asserts it.
- No valid requests means no grant, `in_ready` = 0, and `ptr` unchanged.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0, state `ARB_EMPTY`, lock flag cleared.
- Latency: acceptance in cycle N puts the beat on `out_data` and `out_valid` in cycle N+1.
- Full throughput: with `out_ready` held at 1 and requests continuously present, one beat is accepted every cycle.
- Simultaneous drain and load: the old beat leaves and the new beat is captured on the same edge, and `out_valid` stays 1.
- Fairness: a requester with `in_valid` held is accepted within 4 acceptances (unlocked mode).
- `rst_n` asserted mid-transfer clears everything immediately (asynchronous). An in-flight beat is dropped and `in_ready` goes to 0 combinationally.

## Configuration
- Macro: `RR_MUX_ARB_BURST_EN`.
- Defined:
  - The `in_last` port exists.
  - Accepting a beat with `in_last[sel]`=0 sets `lock`, and `lock_src` ← `sel`.
  - While `lock` is set, `sel` is forced to `lock_src` regardless of the other valids, and `ptr` does not advance.
  - An accepted beat with `in_last`=1 clears `lock` and advances `ptr` to `lock_src`+1.
- Undefined: the `in_last` port is absent, there is no lock logic, and arbitration happens on every beat.

## Structure
- Package `rr_mux_arb_pkg` holds:
  - `N_REQ`=4
  - `typedef logic [1:0] req_idx_t`
  - `typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t`
- Sub-module `rr_pick_4`: combinational rotate-priority picker. Inputs are `req[3:0]` and `ptr`. Outputs are `sel`, `gnt`, and `any`.
- The data select inside the arbiter is a plain 4:1 mux on `sel`.

## Test plan
- Single requester: after reset, `in_valid`=4'b0100 with data 4'hA and `out_ready`=1. Expect `in_ready`=4'b0100 immediately, then `out_data`=4'hA, `out_src`=2, and `out_valid`=1 in the next cycle; `ptr` becomes 3.
- All four requesting continuously (data 1, 2, 3, 4) with `out_ready`=1: `out_src` sequence is 0, 1, 2, 3, 0, … with one beat per cycle and no bubbles.
- Backpressure: `out_ready`=0 for 3 cycles with `out_valid`=1. Expect `out_data` stable, `in_ready`=0, and `ptr` unchanged; on release, the next beat appears the following cycle.
- Drain and load together: `out_valid`=1, `out_ready`=1, `in_valid`=4'b0001. Expect `out_valid` held at 1 and `out_data` to switch to requester 0's value in one edge.
- Reset mid-stall: pull `rst_n` low while `out_valid`=1. Expect `out_valid`=0, `out_src`=0, and `in_ready`=0 immediately; the first grant after release goes to requester 0.
- Burst (with `RR_MUX_ARB_BURST_EN`): requester 1 sends 3 beats with `in_last` set only on the third, while requester 0 is continuously valid. Expect `out_src`=1, 1, 1, then `ptr`=2.
